// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads over a req/ready
// handshake and buffers returned instructions in a small queue ahead of IF/ID.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        q_mem [DEPTH];

    logic          deq;
    logic          enq;
    logic          room;
    logic [31:0]   branch_pc;
    logic          mem_req_d;
    logic [31:0]   mem_addr_d;
    entry_t        head_d;
    logic          if_valid_d;

    // Handshake qualifiers; a branch cancels both the dequeue and any returning data.
    always_comb begin
        deq       = if_valid_o & ~stall_i & ~branch_flag_i;
        enq       = (state_q == REQ) & mem_ready_i & ~branch_flag_i;
        room      = (count_q != CW'(DEPTH)) | deq;
        branch_pc = branch_target_i & ~32'h0000_0003;
    end

    // Next-state, queue pointers and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_o;
        head_d     = '0;
        if_valid_d = 1'b0;

        if (branch_flag_i) begin
            fetch_pc_d = branch_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // A request still waiting for ready must stay on the bus until it completes.
            if (state_q != IDLE && !mem_ready_i) begin
                state_d = DROP;
            end else begin
                state_d = REQ;
            end
        end else begin
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (enq) begin
                wr_ptr_d   = wr_ptr_q + AW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            count_d = count_q + CW'(enq) - CW'(deq);

            unique case (state_q)
                IDLE: begin
                    if (room) begin
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (mem_ready_i) begin
                        state_d = (count_d < CW'(DEPTH)) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (mem_ready_i) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        mem_req_d  = (state_d != IDLE);
        mem_addr_d = (state_d == DROP) ? mem_addr_o : fetch_pc_d;

        // The incoming word becomes the head when it lands in the slot read next.
        if (count_d != '0) begin
            if_valid_d = 1'b1;
            if (enq && (rd_ptr_d == wr_ptr_q)) begin
                head_d.pc   = fetch_pc_q;
                head_d.inst = mem_rdata_i;
            end else begin
                head_d = q_mem[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            if_valid_o <= 1'b0;
            if_pc_o    <= '0;
            if_inst_o  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            mem_req_o  <= mem_req_d;
            mem_addr_o <= mem_addr_d;
            if_valid_o <= if_valid_d;
            if_pc_o    <= head_d.pc;
            if_inst_o  <= head_d.inst;
        end
    end

    // Queue storage needs no reset: emptiness is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_mem[wr_ptr_q] <= '{pc: fetch_pc_q, inst: mem_rdata_i};
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus random traffic, checked by a
// scoreboard holding the expected sequential PC stream since the last redirect.
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;
    logic [31:0] sb_q [$];
    logic [31:0] model_pc;
    logic [31:0] exp_pc;

    logic        prev_ok = 1'b0;
    logic        prev_branch;
    logic        prev_req;
    logic        prev_ready;
    logic [31:0] prev_addr;

    int          waits, n8, gap, n, pops0;
    bit          seen_v, seen8;
    logic [31:0] held, a_hold;
    logic [31:0] a_inst [4];

    inst_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ready_i     (mem_ready_i),
        .mem_rdata_i     (mem_rdata_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction RAM contents: program words at 0..3, a hash everywhere else.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [29:0] w;
        w = a[31:2];
        case (w)
            30'd0:   return 32'h3401_1100;
            30'd1:   return 32'h3402_0020;
            30'd2:   return 32'h0041_1825;
            30'd3:   return 32'h0000_0000;
            default: return {w[15:0], 16'hC0DE} ^ (32'(w) * 32'h9E37_79B1);
        endcase
    endfunction

    assign mem_rdata_i = mem_word(mem_addr_o);

    task automatic check(input logic ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void refill();
        while (sb_q.size() < 8) begin
            sb_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
    endfunction

    task automatic sb_redirect(input logic [31:0] t);
        sb_q.delete();
        model_pc = {t[31:2], 2'b00};
        refill();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc);
        int k;
        k = 0;
        while (!if_valid_o && k < 20) begin
            cyc();
            k++;
        end
        check(if_valid_o && if_pc_o == pc, name, if_pc_o, pc);
    endtask

    task automatic do_reset();
        cyc();
        rst           = 1'b0;
        stall_i       = 1'b0;
        branch_flag_i = 1'b0;
        mem_ready_i   = 1'b1;
        sb_redirect(RESET_PC);
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    // Monitor: reset values, nop-when-empty, flush, address hold and in-order delivery.
    always @(negedge clk) begin
        if (!rst) begin
            check(!mem_req_o && !if_valid_o && mem_addr_o == 0 && if_pc_o == 0 && if_inst_o == 0,
                  "reset_outputs", mem_addr_o | if_pc_o | if_inst_o | {30'd0, mem_req_o, if_valid_o},
                  32'h0);
            prev_ok = 1'b0;
        end else begin
            if (!if_valid_o) check(if_inst_o == 0, "nop_when_empty", if_inst_o, 32'h0);
            if (prev_ok && prev_branch) check(!if_valid_o, "flush_after_branch", 32'(if_valid_o), 32'h0);
            if (prev_ok && prev_req && !prev_ready)
                check(mem_req_o && mem_addr_o == prev_addr, "addr_hold", mem_addr_o, prev_addr);
            if (if_valid_o && !stall_i && !branch_flag_i) begin
                refill();
                exp_pc = sb_q.pop_front();
                check(if_pc_o == exp_pc, "deliver_pc", if_pc_o, exp_pc);
                check(if_inst_o == mem_word(exp_pc), "deliver_inst", if_inst_o, mem_word(exp_pc));
                refill();
                n_pops++;
            end
            prev_ok     = 1'b1;
            prev_branch = branch_flag_i;
            prev_req    = mem_req_o;
            prev_ready  = mem_ready_i;
            prev_addr   = mem_addr_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_inst[0] = 32'h3401_1100;
        a_inst[1] = 32'h3402_0020;
        a_inst[2] = 32'h0041_1825;
        a_inst[3] = 32'h0000_0000;

        // Zero-wait stream straight out of reset.
        rst             = 1'b1;
        stall_i         = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        mem_ready_i     = 1'b1;
        sb_redirect(RESET_PC);
        #1 rst = 1'b0;
        #19 rst = 1'b1;
        cyc();
        check(mem_req_o && mem_addr_o == RESET_PC && !if_valid_o, "first_req", mem_addr_o, RESET_PC);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check(if_valid_o && if_pc_o == 32'(i * 4), "stream_pc", if_pc_o, 32'(i * 4));
            check(if_inst_o == a_inst[i], "stream_inst", if_inst_o, a_inst[i]);
        end

        // RAM wait states on the request for address 8.
        do_reset();
        waits = 0; n8 = 0; gap = 0; seen_v = 1'b0; seen8 = 1'b0;
        for (int i = 0; i < 30 && !seen8; i++) begin
            cyc();
            if (if_valid_o && if_pc_o == 32'h8) begin
                seen8 = 1'b1;
            end else begin
                if (seen_v && !if_valid_o) gap++;
                if (if_valid_o) seen_v = 1'b1;
            end
            if (mem_req_o && mem_addr_o == 32'h8) n8++;
            if (mem_req_o && mem_addr_o == 32'h8 && waits < 3) begin
                mem_ready_i = 1'b0;
                waits++;
            end else begin
                mem_ready_i = 1'b1;
            end
        end
        check(seen8, "wait_delivered", 32'(seen8), 32'h1);
        check(n8 == 4, "wait_addr_cycles", 32'(n8), 32'h4);
        check(gap == 3, "wait_bubble", 32'(gap), 32'h3);

        // Stall until full, then release.
        do_reset();
        repeat (4) cyc();
        held    = if_pc_o;
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check(if_valid_o && if_pc_o == held, "stall_hold", if_pc_o, held);
        end
        check(!mem_req_o, "stall_full_noreq", 32'(mem_req_o), 32'h0);
        stall_i = 1'b0;
        gap = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (!if_valid_o) gap++;
        end
        check(gap <= 1, "stall_release_gap", 32'(gap), 32'h1);

        // Branch while full with the RAM not ready.
        do_reset();
        stall_i = 1'b1;
        repeat (3) cyc();
        n = 0;
        while (mem_req_o && n < 10) begin
            cyc();
            n++;
        end
        check(!mem_req_o && if_valid_o, "full_idle", 32'(mem_req_o), 32'h0);
        mem_ready_i     = 1'b0;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h40;
        sb_redirect(32'h40);
        cyc();
        branch_flag_i = 1'b0;
        stall_i       = 1'b0;
        check(!if_valid_o && mem_req_o && mem_addr_o == 32'h40, "branch_req_target", mem_addr_o, 32'h40);
        cyc();
        cyc();
        mem_ready_i = 1'b1;
        wait_valid("branch_first_pc", 32'h40);
        check(if_inst_o == mem_word(32'h40), "branch_first_inst", if_inst_o, mem_word(32'h40));

        // Branch on a pending request, then a second branch while the old one drains.
        repeat (3) cyc();
        a_hold          = mem_addr_o;
        mem_ready_i     = 1'b0;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h100;
        sb_redirect(32'h100);
        cyc();
        check(mem_req_o && mem_addr_o == a_hold, "drop_addr_hold", mem_addr_o, a_hold);
        branch_target_i = 32'h200;
        sb_redirect(32'h200);
        cyc();
        branch_flag_i = 1'b0;
        cyc();
        mem_ready_i = 1'b1;
        wait_valid("drop_second_target", 32'h200);

        // Branch coinciding with stall and a returning response.
        repeat (3) cyc();
        stall_i         = 1'b1;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h300;
        sb_redirect(32'h300);
        cyc();
        branch_flag_i = 1'b0;
        stall_i       = 1'b0;
        check(!if_valid_o, "stall_branch_flush", 32'(if_valid_o), 32'h0);
        wait_valid("stall_branch_target", 32'h300);

        // Misaligned branch near the top of the address space, then wrap.
        repeat (2) cyc();
        branch_flag_i   = 1'b1;
        branch_target_i = 32'hFFFF_FFFF;
        sb_redirect(32'hFFFF_FFFF);
        cyc();
        branch_flag_i = 1'b0;
        wait_valid("wrap_first", 32'hFFFF_FFFC);
        cyc();
        check(if_valid_o && if_pc_o == 32'h0, "wrap_next", if_pc_o, 32'h0);

        // Asynchronous reset while a request is pending.
        mem_ready_i = 1'b0;
        cyc();
        cyc();
        check(mem_req_o, "pending_req", 32'(mem_req_o), 32'h1);
        rst         = 1'b0;
        mem_ready_i = 1'b1;
        sb_redirect(RESET_PC);
        #1;
        check(!mem_req_o && !if_valid_o && mem_addr_o == 0 && if_pc_o == 0 && if_inst_o == 0,
              "async_reset", mem_addr_o | if_pc_o | if_inst_o | {30'd0, mem_req_o, if_valid_o}, 32'h0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        check(mem_req_o && mem_addr_o == RESET_PC, "restart_req", mem_addr_o, RESET_PC);
        wait_valid("restart_pc", RESET_PC);

        // Random traffic.
        pops0 = n_pops;
        for (int i = 0; i < 400; i++) begin
            cyc();
            stall_i       = ($urandom_range(0, 9) < 3);
            mem_ready_i   = ($urandom_range(0, 9) < 6);
            branch_flag_i = ($urandom_range(0, 24) == 0);
            if (branch_flag_i) begin
                branch_target_i = 32'($urandom_range(0, 4095));
                sb_redirect(branch_target_i);
            end
        end
        cyc();
        stall_i       = 1'b0;
        branch_flag_i = 1'b0;
        mem_ready_i   = 1'b1;
        repeat (5) cyc();
        check(n_pops - pops0 > 40, "random_progress", 32'(n_pops - pops0), 32'd41);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch front end of the openmips core. Sits between the instruction RAM port of top and the IF/ID pipeline register.
- Holds the PC and issues word reads to RAM over a req/ready handshake.
- Buffers returned instructions in a small queue so RAM wait states and decode stalls are decoupled.
- Presents {pc, inst, valid} to IF/ID and honours branch redirects from ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- DEPTH, 2, instruction queue entries (power of two, >= 2).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- stall_i  in  1  IF/ID cannot accept this cycle.
- branch_flag_i  in  1  redirect request from ID.
- branch_target_i  in  32  redirect PC, word-aligned.
- mem_req_o  out  1  read request to instruction RAM.
- mem_addr_o  out  32  byte address of request.
- mem_ready_i  in  1  RAM accepts the request and returns data this cycle.
- mem_rdata_i  in  32  read data, valid when mem_req_o & mem_ready_i.
- if_valid_o  out  1  queue head valid.
- if_pc_o  out  32  PC of queue head.
- if_inst_o  out  32  instruction at queue head; 0 (nop) when if_valid_o=0.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; queue empty; FSM=IDLE.
  - mem_req_o=0, mem_addr_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: mem_req_o=1, mem_addr_o=fetch_pc held stable until mem_ready_i=1.
  - DROP: mem_req_o=1, outstanding request whose data will be discarded.
- Room condition: count<DEPTH, or count==DEPTH and a dequeue occurs this cycle.
- IDLE -> REQ: when room holds (combinational, same cycle). First request appears in the first cycle after rst deasserts.
- REQ with mem_ready_i=1:
  - enqueue {fetch_pc, mem_rdata_i}; fetch_pc += 4 (mod 2^32, wraps silently).
  - Stay in REQ if room still holds next cycle, else go to IDLE.
  - Zero-wait RAM therefore gives 1 instruction/cycle.
- REQ with mem_ready_i=0: hold; mem_addr_o must not change.
- Dequeue: if_valid_o & ~stall_i. Head advances at the clock edge.
- Enqueue and dequeue in the same cycle are legal at any count, including full.
- Fetch latency: data returned in cycle N appears on if_* in cycle N+1 (registered queue). Empty queue yields if_valid_o=0, if_inst_o=0.
- Branch (branch_flag_i=1) has priority over stall, dequeue and enqueue:
  - Queue flushed at the edge; fetch_pc=branch_target_i.
  - if_valid_o=0 next cycle.
  - If a request is in REQ and mem_ready_i=0 that cycle, go to DROP (address kept stable per handshake).
  - If mem_ready_i=1 in the branch cycle, the returned data is discarded and the FSM goes to REQ on the target.
- DROP: on mem_ready_i=1, discard data, go to REQ at fetch_pc (the target).
- A second branch while in DROP updates fetch_pc only.
- Stall: the queue holds; fetching continues until the queue is full, then stops (IDLE).
- Misaligned branch_target_i: low 2 bits forced to 0.
- Reset mid-request: all state cleared immediately; the RAM side must tolerate the request being withdrawn.

Test Plan:
- Zero-wait RAM (mem_ready_i=1), memory words 0..3 = 34011100,34020020,00411825,00000000; release rst at t=20 -> if_pc_o sequence 0,4,8,C on consecutive cycles, if_inst_o matches, first valid 2 cycles after release.
- mem_ready_i low 3 cycles on the request for addr 8 -> mem_addr_o stays 8 for 4 cycles; if_valid_o=0 for 3 cycles after pc 4 is consumed; then pc 8 is delivered, with no duplicates and no skips.
- stall_i=1 for 5 cycles with zero-wait RAM -> queue fills at DEPTH=2, mem_req_o drops to 0, if_pc_o held at the same value; on release, pcs resume in order with no gap beyond 1 cycle.
- branch_flag_i=1, target 0x40, while full and mem_ready_i=0 -> next cycle if_valid_o=0; in-flight data discarded on ready; next valid if_pc_o=0x40 with inst = mem[16].
- Branch in the same cycle as stall and a ready response -> response discarded, queue empty, fetch resumes at target.
- fetch_pc=FFFF_FFFC fetch -> next request addr 0000_0000; rst pulsed low mid-REQ -> all outputs 0 immediately, restart at RESET_PC.
